// File: rtl/pad_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pad_out_serializer
// Brief    : Streams a wide core result (payload + side-band) onto LANE_W
//            output pads per beat, LSB slice first, with a one-deep hold
//            buffer so back-to-back results need no stall.
// Options  : PAD_SER_PARITY_EN - adds out_par, odd parity over
//            {out_lane, out_first} for each valid beat.
// Revision : 1.0 - initial release
// ============================================================================
module pad_out_serializer #(
    parameter int DATA_W = 72,
    parameter int LANE_W = 8,
    parameter int SIDE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic [LANE_W-1:0] out_lane,
    output logic [SIDE_W-1:0] out_side,
    output logic              overflow
`ifdef PAD_SER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    // Derived geometry; the shift register is padded to whole beats so the
    // unused upper bits of a partial last beat come out as zero.
    localparam int             BEATS     = (DATA_W + LANE_W - 1) / LANE_W;
    localparam int             SH_W      = BEATS * LANE_W;
    localparam int             CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // State and datapath flops
    logic [0:0]        state_q,     state_d;
    logic [CNT_W-1:0]  beat_q,      beat_d;
    logic [SH_W-1:0]   shift_q,     shift_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [SIDE_W-1:0] hold_side_q, hold_side_d;
    logic              overflow_q,  overflow_d;

    // Registered pad outputs
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q,  out_last_d;
    logic [LANE_W-1:0] out_lane_q,  out_lane_d;
    logic [SIDE_W-1:0] out_side_q,  out_side_d;

    // Control decisions for this cycle
    logic              is_last;
    logic              take_hold;
    logic              take_in;
    logic              start;
    logic              advance;
    logic [SH_W-1:0]   src_pad;
    logic [SIDE_W-1:0] src_side;

    // The beat currently on the pads is the last one of its frame.
    assign is_last   = (state_q == ST_SEND) && (beat_q == LAST_BEAT);
    // A buffered frame always wins over a fresh strobe at a frame boundary.
    assign take_hold = is_last && hold_full_q;
    assign take_in   = in_valid && ((state_q == ST_IDLE) || (is_last && !hold_full_q));
    assign start     = take_hold || take_in;
    assign advance   = (state_q == ST_SEND) && !is_last;
    assign in_ready  = !hold_full_q || is_last;

    // Select and zero-pad the payload of a frame that starts this cycle.
    always_comb begin
        src_pad = '0;
        if (take_hold) begin
            src_pad[DATA_W-1:0] = hold_data_q;
        end else begin
            src_pad[DATA_W-1:0] = in_data;
        end
        src_side = take_hold ? hold_side_q : in_side;
    end

    // Next-state logic: SEND while beats remain or a new frame starts.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_SEND;
        end else if (is_last) begin
            state_d = ST_IDLE;
        end
    end

    // Hold buffer and sticky overflow: strobes that cannot start a frame
    // are parked if the buffer is free, otherwise dropped.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_side_d = hold_side_q;
        overflow_d  = overflow_q;
        if (take_hold) begin
            hold_full_d = in_valid;
            if (in_valid) begin
                hold_data_d = in_data;
                hold_side_d = in_side;
            end
        end else if (in_valid && advance) begin
            if (!hold_full_q) begin
                hold_full_d = 1'b1;
                hold_data_d = in_data;
                hold_side_d = in_side;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Output and shift datapath: beat 0 is driven straight from the source
    // so the first slice reaches the pads one cycle after the strobe.
    always_comb begin
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        out_lane_d  = '0;
        out_side_d  = out_side_q;
        shift_d     = shift_q;
        beat_d      = '0;
        if (start) begin
            out_valid_d = 1'b1;
            out_first_d = 1'b1;
            out_last_d  = (LAST_BEAT == '0);
            out_lane_d  = src_pad[LANE_W-1:0];
            out_side_d  = src_side;
            shift_d     = src_pad >> LANE_W;
        end else if (advance) begin
            out_valid_d = 1'b1;
            out_last_d  = ((beat_q + CNT_W'(1)) == LAST_BEAT);
            out_lane_d  = shift_q[LANE_W-1:0];
            shift_d     = shift_q >> LANE_W;
            beat_d      = beat_q + CNT_W'(1);
        end else begin
            shift_d     = '0;
        end
    end

    // State register: reset abandons any frame and empties the hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_side_q <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_lane_q  <= '0;
            out_side_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_side_q <= hold_side_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_lane_q  <= out_lane_d;
            out_side_q  <= out_side_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_lane  = out_lane_q;
    assign out_side  = out_side_q;
    assign overflow  = overflow_q;

`ifdef PAD_SER_PARITY_EN
    logic out_par_q, out_par_d;

    // Odd parity over the beat and its first flag; quiet when no beat.
    always_comb begin
        out_par_d = out_valid_d & ~(^{out_lane_d, out_first_d});
    end

    // Parity register, aligned with the other pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_out_serializer
// Brief    : Directed bench for pad_out_serializer (72/8 main instance plus
//            20/8 and 72/72 instances for the partial and single-beat cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_out_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance 72/8
    logic        in_valid;
    logic [71:0] in_data;
    logic [5:0]  in_side;
    logic        in_ready, out_valid, out_first, out_last, overflow;
    logic [7:0]  out_lane;
    logic [5:0]  out_side;

    // Partial-beat instance 20/8
    logic        sm_in_valid;
    logic [19:0] sm_in_data;
    logic [5:0]  sm_in_side;
    logic        sm_in_ready, sm_out_valid, sm_out_first, sm_out_last, sm_overflow;
    logic [7:0]  sm_out_lane;
    logic [5:0]  sm_out_side;

    // Single-beat instance 72/72
    logic        wd_in_valid;
    logic [71:0] wd_in_data;
    logic [5:0]  wd_in_side;
    logic        wd_in_ready, wd_out_valid, wd_out_first, wd_out_last, wd_overflow;
    logic [71:0] wd_out_lane;
    logic [5:0]  wd_out_side;

`ifdef PAD_SER_PARITY_EN
    logic out_par, sm_out_par, wd_out_par;
`endif

    pad_out_serializer #(.DATA_W(72), .LANE_W(8), .SIDE_W(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_side(in_side), .in_ready(in_ready), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .out_lane(out_lane),
        .out_side(out_side), .overflow(overflow)
`ifdef PAD_SER_PARITY_EN
        , .out_par(out_par)
`endif
    );

    pad_out_serializer #(.DATA_W(20), .LANE_W(8), .SIDE_W(6)) u_dut_sm (
        .clk(clk), .rst_n(rst_n), .in_valid(sm_in_valid), .in_data(sm_in_data),
        .in_side(sm_in_side), .in_ready(sm_in_ready), .out_valid(sm_out_valid),
        .out_first(sm_out_first), .out_last(sm_out_last), .out_lane(sm_out_lane),
        .out_side(sm_out_side), .overflow(sm_overflow)
`ifdef PAD_SER_PARITY_EN
        , .out_par(sm_out_par)
`endif
    );

    pad_out_serializer #(.DATA_W(72), .LANE_W(72), .SIDE_W(6)) u_dut_wd (
        .clk(clk), .rst_n(rst_n), .in_valid(wd_in_valid), .in_data(wd_in_data),
        .in_side(wd_in_side), .in_ready(wd_in_ready), .out_valid(wd_out_valid),
        .out_first(wd_out_first), .out_last(wd_out_last), .out_lane(wd_out_lane),
        .out_side(wd_out_side), .overflow(wd_overflow)
`ifdef PAD_SER_PARITY_EN
        , .out_par(wd_out_par)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [71:0] dat [3];
    logic [5:0]  sid [3];
    logic [7:0]  lan [3][9];

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [71:0] d, input logic [5:0] s);
        in_valid = v;
        in_data  = d;
        in_side  = s;
    endtask

    task automatic beat_chk(input string tag, input logic [7:0] lane, input logic first,
                            input logic last, input logic [5:0] side);
        check_val({tag, "_valid"}, out_valid, 1'b1);
        check_val({tag, "_lane"},  out_lane,  lane);
        check_val({tag, "_first"}, out_first, first);
        check_val({tag, "_last"},  out_last,  last);
        check_val({tag, "_side"},  out_side,  side);
`ifdef PAD_SER_PARITY_EN
        check_val({tag, "_par"},   out_par,   ~(^{lane, first}));
`endif
    endtask

    task automatic idle_chk(input string tag);
        check_val({tag, "_valid"}, out_valid, 1'b0);
        check_val({tag, "_lane"},  out_lane,  8'h00);
        check_val({tag, "_first"}, out_first, 1'b0);
        check_val({tag, "_last"},  out_last,  1'b0);
`ifdef PAD_SER_PARITY_EN
        check_val({tag, "_par"},   out_par,   1'b0);
`endif
    endtask

    // Strobe frame 0 now, frame 1 at beat index k2, frame 2 at k3 (-1 = none);
    // expect nfr contiguous frames, overflow from index ovf_k (-1 = never).
    task automatic run_case(input string tag, input int nfr, input int k2, input int k3,
                            input int ovf_k, input logic exp_rdy3);
        drive(1'b1, dat[0], sid[0]);
        @(negedge clk);
        for (int k = 0; k < nfr * 9; k++) begin
            beat_chk($sformatf("%s_k%0d", tag, k), lan[k / 9][k % 9],
                     (k % 9) == 0, (k % 9) == 8, sid[k / 9]);
            check_val($sformatf("%s_ovf%0d", tag, k), overflow, (ovf_k >= 0) && (k >= ovf_k));
            if (k == k2) begin
                drive(1'b1, dat[1], sid[1]);
            end else if (k == k3) begin
                check_val($sformatf("%s_rdy%0d", tag, k), in_ready, exp_rdy3);
                drive(1'b1, dat[2], sid[2]);
            end else begin
                drive(1'b0, '0, '0);
            end
            @(negedge clk);
        end
        idle_chk({tag, "_end"});
        check_val({tag, "_side_hold"}, out_side, sid[nfr - 1]);
    endtask

    initial begin
        dat[0] = 72'h0123456789ABCDEF01;  sid[0] = 6'h2A;
        dat[1] = 72'hFEDCBA9876543210AA;  sid[1] = 6'h15;
        dat[2] = 72'h112233445566778899;  sid[2] = 6'h3F;
        lan[0] = '{8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        lan[1] = '{8'hAA, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        lan[2] = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        sm_in_valid = 1'b0; sm_in_data = '0; sm_in_side = '0;
        wd_in_valid = 1'b0; wd_in_data = '0; wd_in_side = '0;
        repeat (2) @(negedge clk);

        // Reset state
        idle_chk("rst");
        check_val("rst_side",  out_side, 6'h00);
        check_val("rst_ovf",   overflow, 1'b0);
        check_val("rst_ready", in_ready, 1'b1);
        check_val("rst_sm_valid", sm_out_valid, 1'b0);
        check_val("rst_wd_valid", wd_out_valid, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);

        run_case("t1", 1, -1, -1, -1, 1'b0);   // single frame
        run_case("t2", 2,  2, -1, -1, 1'b0);   // second strobe 3 cycles later
        run_case("t4", 3,  0,  8, -1, 1'b1);   // strobe on last beat, hold full
        check_val("t4_ovf", overflow, 1'b0);
        run_case("t3", 2,  0,  1,  2, 1'b0);   // three consecutive strobes
        check_val("t3_ovf", overflow, 1'b1);

        // Reset on beat 4 with a frame parked in the hold buffer
        drive(1'b1, dat[0], sid[0]);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            beat_chk($sformatf("t5_k%0d", k), lan[0][k], k == 0, 1'b0, sid[0]);
            if (k == 0) drive(1'b1, dat[1], sid[1]);
            else        drive(1'b0, '0, '0);
            if (k < 4) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        idle_chk("t5_rst");
        check_val("t5_rst_side",  out_side, 6'h00);
        check_val("t5_rst_ovf",   overflow, 1'b0);
        check_val("t5_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, dat[2], sid[2]);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            beat_chk($sformatf("t5_new%0d", k), lan[2][k], k == 0, k == 8, sid[2]);
            drive(1'b0, '0, '0);
            @(negedge clk);
        end
        idle_chk("t5_end");
        @(negedge clk);
        idle_chk("t5_nohold");

        // Partial last beat (20/8) and single-beat frames (72/72)
        sm_in_valid = 1'b1; sm_in_data = 20'hABCDE; sm_in_side = 6'h01;
        wd_in_valid = 1'b1; wd_in_data = dat[1];    wd_in_side = sid[1];
        @(negedge clk);
        sm_in_valid = 1'b0;
        check_val("sm_b0_lane",  sm_out_lane,  8'hDE);
        check_val("sm_b0_first", sm_out_first, 1'b1);
        check_val("sm_b0_last",  sm_out_last,  1'b0);
        check_val("sm_b0_side",  sm_out_side,  6'h01);
        check_val("wd_b0_valid", wd_out_valid, 1'b1);
        check_val("wd_b0_lane",  wd_out_lane,  dat[1]);
        check_val("wd_b0_first", wd_out_first, 1'b1);
        check_val("wd_b0_last",  wd_out_last,  1'b1);
        check_val("wd_b0_ready", wd_in_ready,  1'b1);
        wd_in_data = dat[2]; wd_in_side = sid[2];
        @(negedge clk);
        wd_in_valid = 1'b0;
        check_val("sm_b1_lane",  sm_out_lane,  8'hBC);
        check_val("sm_b1_last",  sm_out_last,  1'b0);
        check_val("wd_b1_valid", wd_out_valid, 1'b1);
        check_val("wd_b1_lane",  wd_out_lane,  dat[2]);
        check_val("wd_b1_fl",    {wd_out_first, wd_out_last}, 2'b11);
        check_val("wd_b1_side",  wd_out_side,  sid[2]);
        @(negedge clk);
        check_val("sm_b2_valid", sm_out_valid, 1'b1);
        check_val("sm_b2_lane",  sm_out_lane,  8'h0A);
        check_val("sm_b2_last",  sm_out_last,  1'b1);
        check_val("wd_idle",     wd_out_valid, 1'b0);
        @(negedge clk);
        check_val("sm_idle",     sm_out_valid, 1'b0);
        check_val("sm_ovf",      sm_overflow,  1'b0);
        check_val("wd_ovf",      wd_overflow,  1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pad_out_serializer.md
Name: pad_out_serializer

Overview:
- Parametrised output stage between the game core and the output pad ring.
- Accepts a wide core result (board plus side fields) in one cycle and streams it over LANE_W pads per beat, so the chip needs far fewer output pads than a flat 72-bit bus.
- A one-deep hold buffer lets the core issue back-to-back results without stalling.
- Instantiated inside the chip shell in place of direct per-bit output pads.

Parameters:
- DATA_W, 72: width of the wide payload (board image).
- LANE_W, 8: payload bits driven per beat; 1..DATA_W.
- SIDE_W, 6: side-band field (e.g. score, fail, score_valid), held for the whole frame.
- BEATS, ceil(DATA_W/LANE_W): derived; never overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe; capture in_data/in_side
- in_data  in  DATA_W  payload from core
- in_side  in  SIDE_W  side-band from core
- in_ready  out  1  high when a strobe this cycle will not be dropped
- out_valid  out  1  beat valid, to pad
- out_first  out  1  first beat of a frame
- out_last  out  1  last beat of a frame
- out_lane  out  LANE_W  payload slice, to pads
- out_side  out  SIDE_W  side-band, stable across a frame
- overflow  out  1  sticky: a strobe was dropped

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; hold buffer empty; beat counter 0.
- State IDLE:
  - On in_valid, load shift register and side register, then go to SEND.
  - Beat 0 is driven the next cycle (latency 1, all outputs registered).
- State SEND:
  - Each cycle drives out_valid=1 and out_lane = shift[LANE_W-1:0]. The payload goes out LSB first.
  - The shift register then shifts right by LANE_W and the counter increments.
  - out_first=1 on beat 0. out_last=1 on beat BEATS-1.
- Partial last beat: if DATA_W % LANE_W != 0, the unused upper bits of the last beat are 0.
- Back-to-back frames: after the last beat, the next frame follows with no bubble if either:
  - the hold buffer is full, or
  - in_valid is high in that cycle.
  Otherwise the block returns to IDLE and drives out_valid=0 with out_lane=0.
- in_valid during SEND: the strobe goes into the hold buffer if the buffer is empty.
- Last beat, hold full, and in_valid in the same cycle: hold moves to the shift register and the new strobe enters hold. Nothing is dropped.
- Drop case: in_valid while hold is full and the current beat is not last. The strobe is dropped, overflow is set, and it stays set until reset.
- in_ready: !hold_full || (state==SEND && beat==BEATS-1), evaluated combinationally.
- out_side: updated only when a new frame starts; otherwise it holds its value.
- LANE_W == DATA_W: every frame is one beat, and out_first and out_last are both 1.
- Reset mid-frame: the frame is abandoned, outputs drop to 0 asynchronously, and the hold buffer is cleared.

Optional Feature:
- Macro: PAD_SER_PARITY_EN
- Defined:
  - Adds output out_par (1 bit, reset 0) carrying odd parity over out_lane and out_first for each beat.
  - out_par is 0 when out_valid=0.
- Undefined: out_par is absent and the timing is otherwise identical.

Test Plan:
- Reset, then one strobe with in_data=72'h0123456789ABCDEF01, in_side=6'h2A -> 9 beats on consecutive cycles: out_lane 01,EF,CD,AB,89,67,45,23,01; out_first on beat 0, out_last on beat 8; out_side=2A throughout.
- Two strobes 3 cycles apart -> 18 contiguous valid beats with no gap; out_side changes exactly on beat 0 of frame 2; overflow=0.
- Three strobes in consecutive cycles -> third strobe dropped, overflow=1 from the next cycle, in_ready=0 in the drop cycle; only frames 1 and 2 are emitted.
- Strobe coincident with out_last while hold is full -> frames continue back-to-back and overflow stays 0.
- Set DATA_W=20, LANE_W=8 -> 3 beats; beat 2 has upper 4 bits 0. Set LANE_W=72 -> a single beat with out_first=out_last=1.
- Assert rst_n low on beat 4 -> all outputs 0 immediately; after release, a new strobe starts a fresh frame at beat 0. With PAD_SER_PARITY_EN, out_par matches odd parity on every beat.
